// File: rtl/otp_cipher_engine_if.sv
// Valid/ready symbol bus between the loader stage, the OTP cipher engine and the
// display decoder. The master is the stage that feeds symbols and consumes results.
interface otp_cipher_engine_if #(
  parameter int SYM_W = 5,
  parameter int IDX_W = 2
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_text;
  logic [SYM_W-1:0] in_key;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_text;
  logic [IDX_W-1:0] out_index;
  logic             out_err;
  logic             msg_done;

  modport master (
    output mode, in_valid, in_text, in_key, out_ready,
    input  in_ready, out_valid, out_text, out_index, out_err, msg_done
  );

  modport slave (
    input  mode, in_valid, in_text, in_key, out_ready,
    output in_ready, out_valid, out_text, out_index, out_err, msg_done
  );
endinterface

// File: rtl/otp_cipher_engine.sv
// One-time-pad cipher engine: enciphers/deciphers one (text, key) symbol per
// handshake modulo ALPHABET and groups symbols into messages of MSG_LEN.
module otp_cipher_engine #(
  parameter int SYM_W    = 5,
  parameter int ALPHABET = 26,
  parameter int MSG_LEN  = 4,
  parameter int IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  otp_cipher_engine_if.slave   bus
);

  if (ALPHABET < 2 || ALPHABET > (1 << SYM_W)) begin : g_bad_alphabet
    $error("otp_cipher_engine: ALPHABET out of range 2..2^SYM_W");
  end
  if (MSG_LEN < 1) begin : g_bad_msg_len
    $error("otp_cipher_engine: MSG_LEN must be at least 1");
  end

  localparam logic [SYM_W:0]   ALPHA = ALPHABET[SYM_W:0];
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(MSG_LEN - 1);

  typedef enum logic {RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic [SYM_W-1:0] out_text_q, out_text_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic             out_err_q, out_err_d;
  logic             msg_done_q, msg_done_d;

  logic             in_ready;
  logic             accept;
  logic             cur_mode;
  logic [SYM_W:0]   t_ext, k_ext, sum;
  logic [SYM_W-1:0] res;
  logic             sym_err;

  assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  // The first symbol of a message uses the live mode input; later ones the latched copy.
  assign cur_mode = (cnt_q == '0) ? bus.mode : mode_q;

  always_comb begin
    t_ext   = {1'b0, bus.in_text};
    k_ext   = {1'b0, bus.in_key};
    sum     = t_ext + k_ext;
    sym_err = (t_ext >= ALPHA) || (k_ext >= ALPHA);
    res     = '0;
    if (cur_mode) begin
      res = (sum >= ALPHA) ? SYM_W'(sum - ALPHA) : SYM_W'(sum);
    end else begin
      res = (t_ext >= k_ext) ? SYM_W'(t_ext - k_ext) : SYM_W'(t_ext + ALPHA - k_ext);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_text_d  = out_text_q;
    out_index_d = out_index_q;
    out_err_d   = out_err_q;
    msg_done_d  = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_text_d  = sym_err ? '0 : res;
      out_err_d   = sym_err;
      out_index_d = cnt_q;
      if (cnt_q == '0) mode_d = bus.mode;
      if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // The message is only reported complete once its last symbol has left.
    if (state_q == DONE && (!out_valid_q || bus.out_ready)) begin
      msg_done_d = 1'b1;
      state_d    = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_text_q  <= '0;
      out_index_q <= '0;
      out_err_q   <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_text_q  <= out_text_d;
      out_index_q <= out_index_d;
      out_err_q   <= out_err_d;
      msg_done_q  <= msg_done_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_text  = out_text_q;
  assign bus.out_index = out_index_q;
  assign bus.out_err   = out_err_q;
  assign bus.msg_done  = msg_done_q;

endmodule

// File: tb/tb_otp_cipher_engine.sv
// Directed bench for otp_cipher_engine: default 26-letter/4-symbol instance plus a
// MSG_LEN=1, ALPHABET=10 instance, with hand-computed expected symbols.
module tb_otp_cipher_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  otp_cipher_engine_if #(.SYM_W(5), .IDX_W(2)) bus ();
  otp_cipher_engine_if #(.SYM_W(4), .IDX_W(1)) bus1 ();

  otp_cipher_engine #(.SYM_W(5), .ALPHABET(26), .MSG_LEN(4), .IDX_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  otp_cipher_engine #(.SYM_W(4), .ALPHABET(10), .MSG_LEN(1), .IDX_W(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] t, input logic [4:0] k,
                               input logic m);
    bus.in_valid = v;
    bus.in_text  = t;
    bus.in_key   = k;
    bus.mode     = m;
  endtask

  task automatic expectOut(input string tag, input logic [4:0] text,
                           input logic [1:0] idx, input logic err);
    checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, ".text"},  32'(bus.out_text),  32'(text));
    checkOutput({tag, ".index"}, 32'(bus.out_index), 32'(idx));
    checkOutput({tag, ".err"},   32'(bus.out_err),   32'(err));
  endtask

  // Send one pair, then check the registered result one cycle later.
  task automatic sendCheck(input string tag, input logic [4:0] t, input logic [4:0] k,
                           input logic m, input logic [4:0] text, input logic [1:0] idx,
                           input logic err);
    applyStimulus(1'b1, t, k, m);
    tick();
    expectOut(tag, text, idx, err);
  endtask

  // After the last accept: one bubble cycle, then msg_done with in_ready back high.
  task automatic expectBoundary(input string tag);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    #1;
    checkOutput({tag, ".bubble_in_ready"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, ".bubble_msg_done"}, 32'(bus.msg_done), 32'd0);
    tick();
    checkOutput({tag, ".msg_done"}, 32'(bus.msg_done), 32'd1);
    checkOutput({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, ".drained"},  32'(bus.out_valid), 32'd0);
    tick();
    checkOutput({tag, ".msg_done_pulse"}, 32'(bus.msg_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_text   = '0;
    bus1.in_key    = '0;
    bus1.mode      = 1'b0;
    bus1.out_ready = 1'b1;

    tick();
    tick();
    checkOutput("reset.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset.out_text",  32'(bus.out_text),  32'd0);
    checkOutput("reset.out_index", 32'(bus.out_index), 32'd0);
    checkOutput("reset.out_err",   32'(bus.out_err),   32'd0);
    checkOutput("reset.msg_done",  32'(bus.msg_done),  32'd0);
    checkOutput("reset.in_ready",  32'(bus.in_ready),  32'd1);
    rst = 1'b1;
    tick();

    $display("[TB] decrypt message");
    sendCheck("dec0", 5'd7,  5'd3,  1'b0, 5'd4,  2'd0, 1'b0);
    sendCheck("dec1", 5'd2,  5'd5,  1'b0, 5'd23, 2'd1, 1'b0);
    sendCheck("dec2", 5'd25, 5'd25, 1'b0, 5'd0,  2'd2, 1'b0);
    sendCheck("dec3", 5'd0,  5'd1,  1'b0, 5'd25, 2'd3, 1'b0);
    expectBoundary("dec_end");

    $display("[TB] encrypt message, mode dropped after first symbol");
    sendCheck("enc0", 5'd20, 5'd10, 1'b1, 5'd4, 2'd0, 1'b0);
    sendCheck("enc1", 5'd25, 5'd1,  1'b0, 5'd0, 2'd1, 1'b0);
    sendCheck("enc2", 5'd3,  5'd4,  1'b0, 5'd7, 2'd2, 1'b0);
    sendCheck("enc3", 5'd0,  5'd0,  1'b0, 5'd0, 2'd3, 1'b0);
    expectBoundary("enc_end");

    $display("[TB] backpressure");
    sendCheck("bp0", 5'd10, 5'd1, 1'b0, 5'd9, 2'd0, 1'b0);
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b0);
    bus.out_ready = 1'b0;
    #1;
    checkOutput("bp.hold_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expectOut("bp.hold", 5'd9, 2'd0, 1'b0);
      checkOutput("bp.hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp.release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    expectOut("bp1", 5'd0, 2'd1, 1'b0);
    sendCheck("bp2", 5'd1,  5'd2, 1'b0, 5'd25, 2'd2, 1'b0);
    sendCheck("bp3", 5'd12, 5'd0, 1'b0, 5'd12, 2'd3, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    bus.out_ready = 1'b0;
    tick();
    checkOutput("bp.done_held_msg_done", 32'(bus.msg_done), 32'd0);
    expectOut("bp.done_held", 5'd12, 2'd3, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp.done_msg_done", 32'(bus.msg_done), 32'd1);
    checkOutput("bp.done_drained",  32'(bus.out_valid), 32'd0);
    tick();

    $display("[TB] invalid symbol");
    sendCheck("inv0", 5'd4,  5'd1, 1'b0, 5'd3, 2'd0, 1'b0);
    sendCheck("inv1", 5'd27, 5'd2, 1'b0, 5'd0, 2'd1, 1'b1);
    sendCheck("inv2", 5'd9,  5'd2, 1'b0, 5'd7, 2'd2, 1'b0);
    sendCheck("inv3", 5'd3,  5'd3, 1'b0, 5'd0, 2'd3, 1'b0);
    expectBoundary("inv_end");

    $display("[TB] reset mid-message");
    sendCheck("rm0", 5'd1, 5'd0, 1'b0, 5'd1, 2'd0, 1'b0);
    sendCheck("rm1", 5'd2, 5'd0, 1'b0, 5'd2, 2'd1, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0);
    rst = 1'b0;
    tick();
    checkOutput("rm.rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rm.rst_out_text",  32'(bus.out_text),  32'd0);
    checkOutput("rm.rst_out_index", 32'(bus.out_index), 32'd0);
    checkOutput("rm.rst_out_err",   32'(bus.out_err),   32'd0);
    checkOutput("rm.rst_msg_done",  32'(bus.msg_done),  32'd0);
    rst = 1'b1;
    sendCheck("rm2", 5'd5, 5'd1, 1'b0, 5'd4, 2'd0, 1'b0);
    sendCheck("rm3", 5'd5, 5'd2, 1'b0, 5'd3, 2'd1, 1'b0);
    sendCheck("rm4", 5'd5, 5'd3, 1'b0, 5'd2, 2'd2, 1'b0);
    checkOutput("rm.no_early_done", 32'(bus.msg_done), 32'd0);
    sendCheck("rm5", 5'd5, 5'd4, 1'b0, 5'd1, 2'd3, 1'b0);
    expectBoundary("rm_end");

    $display("[TB] MSG_LEN=1 ALPHABET=10 instance");
    bus1.in_valid = 1'b1;
    bus1.in_text  = 4'd3;
    bus1.in_key   = 4'd7;
    tick();
    checkOutput("p1.valid",    32'(bus1.out_valid), 32'd1);
    checkOutput("p1.text",     32'(bus1.out_text),  32'd6);
    checkOutput("p1.index",    32'(bus1.out_index), 32'd0);
    checkOutput("p1.err",      32'(bus1.out_err),   32'd0);
    bus1.in_valid = 1'b0;
    #1;
    checkOutput("p1.in_ready", 32'(bus1.in_ready),  32'd0);
    tick();
    checkOutput("p1.msg_done", 32'(bus1.msg_done),  32'd1);
    bus1.in_valid = 1'b1;
    bus1.in_text  = 4'd11;
    bus1.in_key   = 4'd2;
    tick();
    checkOutput("p2.text",     32'(bus1.out_text),  32'd0);
    checkOutput("p2.err",      32'(bus1.out_err),   32'd1);
    checkOutput("p2.index",    32'(bus1.out_index), 32'd0);
    bus1.in_valid = 1'b0;
    tick();
    checkOutput("p2.msg_done", 32'(bus1.msg_done),  32'd1);
    tick();
    checkOutput("p2.msg_done_pulse", 32'(bus1.msg_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
